// File: rtl/cordic_rotator_pkg.sv
// Shared constants for the rotation-mode CORDIC engine: FSM encoding,
// Q2.30 angle constants and the arctangent lookup table.
package cordic_rotator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int          ATAN_ENTRIES = 30;
   localparam logic [31:0] INV_K        = 32'h26DD3B6A;
   localparam logic [31:0] PI_2         = 32'h6487ED51;
   localparam logic [31:0] PI_4         = 32'h3243F6A8;

   // round(atan(2^-i) * 2^30), evaluated at elaboration time. Entry 0 is
   // pi/4 rounded to nearest; the others come from the alternating series
   // atan(t) = t - t^3/3 + t^5/5 - ..., summed at 2^61 scale.
   function automatic logic [31:0] atan_q30(input int i);
      longint acc;
      longint term;
      int     e;
      if (i == 0) begin
         return 32'h3243F6A9;
      end else begin
         acc = 64'sd0;
         for (int k = 0; k < 31; k++) begin
            e = 61 - i * (2 * k + 1);
            if (e >= 0) begin
               term = (64'sd1 <<< e) / longint'(2 * k + 1);
               if ((k % 2) == 0) begin
                  acc = acc + term;
               end else begin
                  acc = acc - term;
               end
            end else begin
               term = 64'sd0;
            end
         end
         return 32'((acc + (64'sd1 <<< 30)) >>> 31);
      end
   endfunction

   // 32-entry table so a 5-bit counter indexes it directly; entries 30/31 unused.
   function automatic logic [31:0][31:0] build_atan_table();
      logic [31:0][31:0] t;
      for (int i = 0; i < 32; i++) begin
         if (i < ATAN_ENTRIES) begin
            t[i] = atan_q30(i);
         end else begin
            t[i] = 32'd0;
         end
      end
      return t;
   endfunction

   localparam logic [31:0][31:0] ATAN_TABLE = build_atan_table();

endpackage

// File: rtl/cordic_rotator_micro_rotation.sv
// One CORDIC micro-rotation step: rotate (x, y) by +/-atan(2^-i) depending on
// the sign of the residual angle z, driving z toward zero.
module cordic_micro_rotation
   import cordic_rotator_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   input  logic [4:0]       shift,
   input  logic [WIDTH-1:0] atan_in,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out
);

   logic signed [WIDTH-1:0] x_sh_s;
   logic signed [WIDTH-1:0] y_sh_s;

   // Sign-extending shifts of the pre-update coordinates.
   always_comb begin
      x_sh_s = $signed(x_in) >>> shift;
      y_sh_s = $signed(y_in) >>> shift;
   end

   // Add/subtract scheme chosen by the sign of z; arithmetic wraps modulo 2^WIDTH.
   always_comb begin
      if (z_in[WIDTH-1] == 1'b0) begin
         x_out = x_in - y_sh_s;
         y_out = y_in + x_sh_s;
         z_out = z_in - atan_in;
      end else begin
         x_out = x_in + y_sh_s;
         y_out = y_in - x_sh_s;
         z_out = z_in + atan_in;
      end
   end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock under an
// IDLE/RUN/DONE FSM with a start/done handshake.
module cordic_rotator
   import cordic_rotator_pkg::*;
#(
   parameter int ITERATIONS = 16,
   parameter int WIDTH      = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out
);

   localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

   state_e           state_q, state_d;
   logic [4:0]       iter_q, iter_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] atan_s;
   logic [WIDTH-1:0] x_rot_s, y_rot_s, z_rot_s;

   // Arctangent for the current iteration.
   always_comb begin
      atan_s = WIDTH'(ATAN_TABLE[iter_q]);
   end

   cordic_micro_rotation #(.WIDTH(WIDTH)) u_micro (
      .x_in    (x_q),
      .y_in    (y_q),
      .z_in    (z_q),
      .shift   (iter_q),
      .atan_in (atan_s),
      .x_out   (x_rot_s),
      .y_out   (y_rot_s),
      .z_out   (z_rot_s)
   );

   // Next-state, counter and working-register update; busy/done follow the next state.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               x_d     = x_in;
               y_d     = y_in;
               z_d     = z_in;
               iter_d  = 5'd0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            x_d = x_rot_s;
            y_d = y_rot_s;
            z_d = z_rot_s;
            if (iter_q == LAST_ITER) begin
               state_d = ST_DONE;
            end else begin
               iter_d = iter_q + 5'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         iter_q  <= 5'd0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign x_out = x_q;
   assign y_out = y_q;
   assign z_out = z_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: directed and random rotations
// compared against a floating-point-derived reference model.
module tb_cordic_rotator;
   import cordic_rotator_pkg::*;

   localparam int ITER = 16;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [31:0] x_in, y_in, z_in;
   logic        busy, done;
   logic [31:0] x_out, y_out, z_out;

   int tests = 0;
   int fails = 0;
   int ref_atan [30];

   always #5 clock = ~clock;

   cordic_rotator #(.ITERATIONS(ITER), .WIDTH(32)) dut (
      .clock (clock), .reset (reset), .start (start),
      .x_in  (x_in),  .y_in  (y_in),  .z_in  (z_in),
      .busy  (busy),  .done  (done),
      .x_out (x_out), .y_out (y_out), .z_out (z_out)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
      int   diff;
      logic ok;
      diff = int'(obs - exp);
      ok   = (diff <= tol) && (diff >= -tol);
      tests++;
      assert (ok === 1'b1) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp, tol);
      end
   endtask

   // Straight application of the rotation rules for ITER steps.
   task automatic ref_rotate(input logic [31:0] x0, y0, z0, output logic [31:0] xr, yr, zr);
      int x, y, z, xn;
      x = int'(x0); y = int'(y0); z = int'(z0);
      for (int i = 0; i < ITER; i++) begin
         if (z >= 0) begin
            xn = x - (y >>> i); y = y + (x >>> i); z = z - ref_atan[i];
         end else begin
            xn = x + (y >>> i); y = y - (x >>> i); z = z + ref_atan[i];
         end
         x = xn;
      end
      xr = x; yr = y; zr = z;
   endtask

   task automatic drive(input logic [31:0] x, y, z);
      x_in = x; y_in = y; z_in = z;
   endtask

   // One isolated operation: latency, busy length, exclusivity, result, hold.
   task automatic check_op(input string tag, input logic [31:0] x, y, z);
      int lat, busy_cnt;
      logic [31:0] ex, ey, ez;
      ref_rotate(x, y, z, ex, ey, ez);
      drive(x, y, z);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0; busy_cnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         busy_cnt += int'(busy);
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(ITER));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(ITER));
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_x"}, x_out, ex);
      check({tag, "_y"}, y_out, ey);
      check({tag, "_z"}, z_out, ez);
      drive(~x, ~y, ~z);
      tick();
      check({tag, "_done_pulse_width"}, {31'd0, done}, 32'd0);
      check({tag, "_x_hold"}, x_out, ex);
   endtask

   initial begin
      logic [31:0] ex, ey, ez, rx, ry, rz;
      logic [31:0] bx [3], by [3], bz [3];
      int n, k, dones, first_done;
      int exp_n [3];

      for (int i = 0; i < 30; i++) begin
         ref_atan[i] = $rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** 30) + 0.5);
      end

      // Reset state
      reset = 1'b1; start = 1'b0; drive(32'd0, 32'd0, 32'd0);
      tick(); tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_x", x_out, 32'd0);
      check("rst_y", y_out, 32'd0);
      check("rst_z", z_out, 32'd0);
      reset = 1'b0;
      tick();

      // Directed angles with gain-compensated unit vector
      check_op("z0", INV_K, 32'd0, 32'd0);
      check_near("z0_cos", x_out, 32'h40000000, 32'h10000);
      check_near("z0_sin", y_out, 32'h00000000, 32'h10000);
      check_op("pi4", INV_K, 32'd0, PI_4);
      check_near("pi4_cos", x_out, 32'h2D413CCD, 32'h10000);
      check_near("pi4_sin", y_out, 32'h2D413CCD, 32'h10000);
      check_near("pi4_resid", z_out, 32'h0, 32'h10000);
      check_op("mpi4", INV_K, 32'd0, 32'hCDBC0958);
      check_near("mpi4_cos", x_out, 32'h2D413CCD, 32'h10000);
      check_near("mpi4_sin", y_out, 32'hD2BEC333, 32'h10000);
      check_op("pi2", INV_K, 32'd0, PI_2);
      check_near("pi2_sin", y_out, 32'h40000000, 32'h10000);

      // Random operands inside the legal range
      for (int r = 0; r < 6; r++) begin
         rx = $urandom_range(32'h4CCCCCCC) - 32'h26666666;
         ry = $urandom_range(32'h4CCCCCCC) - 32'h26666666;
         rz = $urandom_range(32'hC90FDAA2) - PI_2;
         check_op($sformatf("rand%0d", r), rx, ry, rz);
      end

      // Start pulsed mid-RUN is ignored
      ref_rotate(INV_K, 32'd0, PI_4, ex, ey, ez);
      drive(INV_K, 32'd0, PI_4);
      start = 1'b1; tick(); start = 1'b0;
      n = 0; dones = 0; first_done = -1;
      for (int c = 0; c < 40; c++) begin
         if (n == 3) begin
            drive(32'h11111111, 32'h12345678, 32'hE0000000);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            dones++;
            if (first_done < 0) begin
               first_done = n;
               rx = x_out; ry = y_out; rz = z_out;
            end
         end
         tick();
         n++;
      end
      start = 1'b0;
      check("ignore_done_count", 32'(dones), 32'd1);
      check("ignore_done_time", 32'(first_done), 32'(ITER));
      check("ignore_x", rx, ex);
      check("ignore_y", ry, ey);
      check("ignore_z", rz, ez);

      // Reset mid-RUN aborts without a done pulse
      drive(INV_K, 32'd0, PI_4);
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_x", x_out, 32'd0);
      check("abort_y", y_out, 32'd0);
      check("abort_z", z_out, 32'd0);
      tick(); tick();
      reset = 1'b0;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         dones += int'(done);
         tick();
      end
      check("abort_no_done", 32'(dones), 32'd0);
      check_op("after_abort", INV_K, 32'd0, 32'hE0000000);

      // Start held high: three back-to-back operations
      bx[0] = INV_K;        by[0] = 32'd0;        bz[0] = PI_4;
      bx[1] = 32'h1A2B3C4D; by[1] = 32'hF0F0F0F0; bz[1] = 32'hB0000000;
      bx[2] = 32'hE6666666; by[2] = 32'h19999999; bz[2] = 32'h40000000;
      exp_n[0] = ITER; exp_n[1] = 2 * ITER + 1; exp_n[2] = 3 * ITER + 2;
      drive(bx[0], by[0], bz[0]);
      start = 1'b1; tick();
      drive(bx[1], by[1], bz[1]);
      n = 0; k = 0;
      while (k < 3 && n < 70) begin
         if (done === 1'b1) begin
            ref_rotate(bx[k], by[k], bz[k], ex, ey, ez);
            check($sformatf("b2b%0d_time", k), 32'(n), 32'(exp_n[k]));
            check($sformatf("b2b%0d_x", k), x_out, ex);
            check($sformatf("b2b%0d_y", k), y_out, ey);
            check($sformatf("b2b%0d_z", k), z_out, ez);
            if (k == 2) start = 1'b0;
            k++;
            tick(); n++;
            if (k == 1) drive(bx[2], by[2], bz[2]);
         end else begin
            tick(); n++;
         end
      end
      start = 1'b0;
      check("b2b_count", 32'(k), 32'd3);
      tick();
      check("b2b_idle_after", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
